pipe_stall_ctrl: RTL

//  Hazard/stall controller that drives the write-enable side of the ID/EX pipeline register.
//  - Generates the hold and bubble controls for PC, IF/ID, ID/EX and EX/MEM.
//  - Detects integer and FP load-use hazards.
//  - Freezes the pipe while a multi-cycle FP op occupies EX.
//  - Counts stall cycles for performance monitoring.

---
 rtl/pipe_stall_ctrl_pkg.sv | 25 ++
 rtl/pipe_stall_ctrl_if.sv | 59 +++++
 rtl/pipe_stall_ctrl_hazard_detect.sv | 44 ++++
 rtl/pipe_stall_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl_pkg
// Purpose  : Shared definitions for the stall controller and its hazard
//            compare: FSM state encoding, architectural zero register,
//            default field widths.
// Ports    : (package - none)
// Revision : 1.0  initial release
// ============================================================================
package pipe_stall_ctrl_pkg;

  localparam int LAT_W_DEF  = 4;
  localparam int PERF_W_DEF = 16;

  // Integer register 0 is hard-wired to zero, so a load into it never
  // creates a real dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_MCBUSY = 1'b1
  } state_e;

endpackage : pipe_stall_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl_if
// Purpose  : Bundle between the pipeline datapath and the stall controller.
//            slave  : controller side (hazard inputs in, enables out)
//            master : pipeline side  (hazard inputs out, enables in)
// Signals  : id_* ID-stage source info, ex_* EX-stage destination/op info,
//            br_flush taken-branch squash, pcWrite/ifIdWrite/idExWrite/
//            exMemWrite enables, idExBubble NOP insert, busy, stallCnt.
// Revision : 1.0  initial release
// ============================================================================
interface pipe_stall_ctrl_if #(
  parameter int LAT_W  = 4,
  parameter int PERF_W = 16
);

  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_usesRs;
  logic              id_usesRt;
  logic [4:0]        id_fp_rs;
  logic [4:0]        id_fp_rt;
  logic              id_usesFp;
  logic              ex_memRead;
  logic [4:0]        ex_rW;
  logic              ex_fp_load;
  logic [4:0]        ex_fp_rW;
  logic              ex_fp_mcStart;
  logic [LAT_W-1:0]  ex_fp_lat;
  logic              br_flush;

  logic              pcWrite;
  logic              ifIdWrite;
  logic              idExWrite;
  logic              idExBubble;
  logic              exMemWrite;
  logic              busy;
  logic [PERF_W-1:0] stallCnt;

  modport master (
    output id_rs, id_rt, id_usesRs, id_usesRt,
    output id_fp_rs, id_fp_rt, id_usesFp,
    output ex_memRead, ex_rW, ex_fp_load, ex_fp_rW,
    output ex_fp_mcStart, ex_fp_lat, br_flush,
    input  pcWrite, ifIdWrite, idExWrite, idExBubble, exMemWrite,
    input  busy, stallCnt
  );

  modport slave (
    input  id_rs, id_rt, id_usesRs, id_usesRt,
    input  id_fp_rs, id_fp_rt, id_usesFp,
    input  ex_memRead, ex_rW, ex_fp_load, ex_fp_rW,
    input  ex_fp_mcStart, ex_fp_lat, br_flush,
    output pcWrite, ifIdWrite, idExWrite, idExBubble, exMemWrite,
    output busy, stallCnt
  );

endinterface : pipe_stall_ctrl_if
`default_nettype wire

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl_hazard_detect
// Purpose  : Purely combinational load-use compare between the instruction
//            in ID and a load sitting in EX. Shared with the forwarding unit.
// Ports    : i_id_*   ID source registers and their use flags
//            i_ex_*   EX load flags and destination registers
//            o_lu_int integer load-use hazard
//            o_lu_fp  FP load-use hazard
// Revision : 1.0  initial release
// ============================================================================
module pipe_stall_ctrl_hazard_detect
  import pipe_stall_ctrl_pkg::*;
(
  input  wire logic [4:0] i_id_rs,
  input  wire logic [4:0] i_id_rt,
  input  wire logic       i_id_usesRs,
  input  wire logic       i_id_usesRt,
  input  wire logic [4:0] i_id_fp_rs,
  input  wire logic [4:0] i_id_fp_rt,
  input  wire logic       i_id_usesFp,
  input  wire logic       i_ex_memRead,
  input  wire logic [4:0] i_ex_rW,
  input  wire logic       i_ex_fp_load,
  input  wire logic [4:0] i_ex_fp_rW,
  output logic            o_lu_int,
  output logic            o_lu_fp
);

  logic w_rs_hit;
  logic w_rt_hit;
  logic w_fp_hit;

  assign w_rs_hit = i_id_usesRs & (i_id_rs == i_ex_rW);
  assign w_rt_hit = i_id_usesRt & (i_id_rt == i_ex_rW);

  // FP register 0 is a real register, so no zero-register exclusion here.
  assign w_fp_hit = (i_id_fp_rs == i_ex_fp_rW) | (i_id_fp_rt == i_ex_fp_rW);

  assign o_lu_int = i_ex_memRead & (i_ex_rW != REG_ZERO) & (w_rs_hit | w_rt_hit);
  assign o_lu_fp  = i_ex_fp_load & i_id_usesFp & w_fp_hit;

endmodule : pipe_stall_ctrl_hazard_detect
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Purpose  : Hazard/stall controller. Produces the PC, IF/ID, ID/EX and
//            EX/MEM write enables plus the ID/EX bubble, freezes the pipe
//            while a multi-cycle FP op occupies EX, and counts stall cycles.
// Ports    : clk    rising-edge clock
//            rst_n  asynchronous active-low reset
//            bus    pipe_stall_ctrl_if.slave (hazard inputs, enables,
//                   busy flag, stall-cycle counter)
// Revision : 1.0  initial release
// ============================================================================
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int LAT_W  = LAT_W_DEF,
  parameter int PERF_W = PERF_W_DEF
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  pipe_stall_ctrl_if.slave bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [LAT_W-1:0]  r_cnt;
  logic [LAT_W-1:0]  w_cnt_nxt;
  logic [PERF_W-1:0] r_stall_cnt;

  logic w_lu_int;
  logic w_lu_fp;
  logic w_lu;
  logic w_mc;

  logic w_pc_wr;
  logic w_ifid_wr;
  logic w_idex_wr;
  logic w_idex_bub;
  logic w_exmem_wr;

  pipe_stall_ctrl_hazard_detect u_hazard_detect (
    .i_id_rs      (bus.id_rs),
    .i_id_rt      (bus.id_rt),
    .i_id_usesRs  (bus.id_usesRs),
    .i_id_usesRt  (bus.id_usesRt),
    .i_id_fp_rs   (bus.id_fp_rs),
    .i_id_fp_rt   (bus.id_fp_rt),
    .i_id_usesFp  (bus.id_usesFp),
    .i_ex_memRead (bus.ex_memRead),
    .i_ex_rW      (bus.ex_rW),
    .i_ex_fp_load (bus.ex_fp_load),
    .i_ex_fp_rW   (bus.ex_fp_rW),
    .o_lu_int     (w_lu_int),
    .o_lu_fp      (w_lu_fp)
  );

  assign w_lu = w_lu_int | w_lu_fp;

  // Latencies of 0 or 1 complete in a single EX cycle and need no freeze.
  assign w_mc = bus.ex_fp_mcStart & (bus.ex_fp_lat >= LAT_W'(2));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and pipeline controls
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pc_wr     = 1'b1;
    w_ifid_wr   = 1'b1;
    w_idex_wr   = 1'b1;
    w_idex_bub  = 1'b0;
    w_exmem_wr  = 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (bus.br_flush) begin
          // The squashed ID instruction is replaced by a NOP; whatever hazard
          // it appeared to have is moot.
          w_idex_bub = 1'b1;
        end else if (w_mc) begin
          // The mcStart cycle is the first frozen cycle, so the remaining
          // frozen cycles after this one are lat-2.
          w_pc_wr    = 1'b0;
          w_ifid_wr  = 1'b0;
          w_idex_wr  = 1'b0;
          w_exmem_wr = 1'b0;
          w_cnt_nxt  = bus.ex_fp_lat - LAT_W'(2);
          if (bus.ex_fp_lat != LAT_W'(2)) begin
            w_state_nxt = ST_MCBUSY;
          end
        end else if (w_lu) begin
          w_pc_wr    = 1'b0;
          w_ifid_wr  = 1'b0;
          w_idex_bub = 1'b1;
        end
      end

      ST_MCBUSY: begin
        // ID/EX are frozen, so hazard and flush inputs are simply re-seen
        // once the freeze ends.
        w_pc_wr    = 1'b0;
        w_ifid_wr  = 1'b0;
        w_idex_wr  = 1'b0;
        w_exmem_wr = 1'b0;
        w_cnt_nxt  = r_cnt - LAT_W'(1);
        if (r_cnt == LAT_W'(1)) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Stall-cycle counter, wraps silently
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!w_pc_wr) begin
      r_stall_cnt <= r_stall_cnt + PERF_W'(1);
    end
  end

  // Enables are forced low while reset is held: the IDLE defaults would
  // otherwise let the pipe advance during reset.
  assign bus.pcWrite    = w_pc_wr    & rst_n;
  assign bus.ifIdWrite  = w_ifid_wr  & rst_n;
  assign bus.idExWrite  = w_idex_wr  & rst_n;
  assign bus.idExBubble = w_idex_bub & rst_n;
  assign bus.exMemWrite = w_exmem_wr & rst_n;
  assign bus.busy       = (r_state == ST_MCBUSY);
  assign bus.stallCnt   = r_stall_cnt;

endmodule : pipe_stall_ctrl
`default_nettype wire
